// File: rtl/spi_slave_mem_bridge.sv
// spi_slave_mem_bridge: oversampled SPI slave that turns framed commands into memory-bus reads and writes
module spi_slave_mem_bridge #(
    parameter int ADDR_WIDTH  = 7,
    parameter int DATA_WIDTH  = 8,
    parameter int SPI_MODE    = 0,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  sck_i,
    input  logic                  cs_ni,
    input  logic                  sdi_i,
    output logic                  sdo_o,
    output logic                  sdo_oe_o,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic [DATA_WIDTH-1:0] write_data_o,
    output logic                  write_en_o,
    output logic                  read_en_o,
    input  logic [DATA_WIDTH-1:0] read_data_i,
    input  logic                  read_valid_i,
    output logic                  busy_o,
    output logic                  frame_err_o,
    output logic                  rd_underrun_o
);
    localparam logic CPOL = SPI_MODE[1];
    localparam logic CPHA = SPI_MODE[0];
    localparam int RW = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
    localparam int CW = $clog2(RW + 1);

    typedef enum logic [1:0] {IDLE, CMD, ADDR, DATA} state_t;

    logic [SYNC_STAGES-1:0] sck_q, cs_q, sdi_q;
    logic                   sck_dly_q, cs_dly_q;
    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [RW-2:0]          rx_q, rx_d;
    logic [DATA_WIDTH-1:0]  tx_q, tx_d, tx_now, wdata_q, wdata_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic                   cmd_q, cmd_d, pend_q, pend_d, inc_q, inc_d, sdo_q, sdo_d;
    logic                   wen_q, wen_d, ren_q, ren_d, ferr_q, ferr_d, urun_q, urun_d;
    logic                   sck_s, cs_s, sdi_s, sample, shift, cs_fall, cs_rise, cap;

    assign sck_s   = sck_q[SYNC_STAGES-1];
    assign cs_s    = cs_q[SYNC_STAGES-1];
    assign sdi_s   = sdi_q[SYNC_STAGES-1];
    assign sample  = (CPOL == CPHA) ? (sck_s & ~sck_dly_q) : (~sck_s & sck_dly_q);
    assign shift   = (CPOL == CPHA) ? (~sck_s & sck_dly_q) : (sck_s & ~sck_dly_q);
    assign cs_fall = ~cs_s & cs_dly_q;
    assign cs_rise = cs_s & ~cs_dly_q;
    assign cap     = pend_q & read_valid_i;
    assign tx_now  = cap ? read_data_i : tx_q;

    assign sdo_oe_o      = (state_q == DATA) & cmd_q;
    assign sdo_o         = sdo_q & sdo_oe_o;
    assign addr_o        = addr_q;
    assign write_data_o  = wdata_q;
    assign write_en_o    = wen_q;
    assign read_en_o     = ren_q;
    assign busy_o        = state_q != IDLE;
    assign frame_err_o   = ferr_q;
    assign rd_underrun_o = urun_q;

    // Synchronise the pins and keep one extra delayed copy of SCK and CS for edge detection
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sck_q     <= {SYNC_STAGES{CPOL}};
            cs_q      <= '1;
            sdi_q     <= '0;
            sck_dly_q <= CPOL;
            cs_dly_q  <= 1'b1;
        end else begin
            sck_q     <= {sck_q[SYNC_STAGES-2:0], sck_i};
            cs_q      <= {cs_q[SYNC_STAGES-2:0], cs_ni};
            sdi_q     <= {sdi_q[SYNC_STAGES-2:0], sdi_i};
            sck_dly_q <= sck_s;
            cs_dly_q  <= cs_s;
        end
    end

    // Frame state and datapath registers
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rx_q    <= '0;
            tx_q    <= '0;
            wdata_q <= '0;
            addr_q  <= '0;
            cmd_q   <= 1'b0;
            pend_q  <= 1'b0;
            inc_q   <= 1'b0;
            sdo_q   <= 1'b0;
            wen_q   <= 1'b0;
            ren_q   <= 1'b0;
            ferr_q  <= 1'b0;
            urun_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rx_q    <= rx_d;
            tx_q    <= tx_d;
            wdata_q <= wdata_d;
            addr_q  <= addr_d;
            cmd_q   <= cmd_d;
            pend_q  <= pend_d;
            inc_q   <= inc_d;
            sdo_q   <= sdo_d;
            wen_q   <= wen_d;
            ren_q   <= ren_d;
            ferr_q  <= ferr_d;
            urun_q  <= urun_d;
        end
    end

    // Next state: frame decode, bus strobes, read-data capture and MISO shifting
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rx_d    = rx_q;
        tx_d    = tx_q;
        wdata_d = wdata_q;
        addr_d  = inc_q ? addr_q + ADDR_WIDTH'(1) : addr_q;
        cmd_d   = cmd_q;
        pend_d  = cap ? 1'b0 : pend_q;
        inc_d   = 1'b0;
        sdo_d   = sdo_q;
        wen_d   = 1'b0;
        ren_d   = 1'b0;
        ferr_d  = 1'b0;
        urun_d  = 1'b0;
        if (cap)
            tx_d = read_data_i;
        if (state_q == IDLE) begin
            sdo_d = 1'b0;
            if (cs_fall) begin
                state_d = CMD;
                cnt_d   = '0;
            end
        end else if (cs_rise) begin
            state_d = IDLE;
            pend_d  = 1'b0;
            ferr_d  = (state_q != DATA) || (cnt_q != '0);
        end else begin
            if (sample) begin
                rx_d  = {rx_q[RW-3:0], sdi_s};
                cnt_d = cnt_q + CW'(1);
                if (state_q == CMD) begin
                    cmd_d   = sdi_s;
                    state_d = ADDR;
                    cnt_d   = '0;
                end else if (state_q == ADDR && cnt_q == CW'(ADDR_WIDTH - 1)) begin
                    addr_d  = {rx_q[ADDR_WIDTH-2:0], sdi_s};
                    state_d = DATA;
                    cnt_d   = '0;
                    ren_d   = cmd_q;
                    pend_d  = cmd_q;
                end else if (state_q == DATA && cnt_q == CW'(DATA_WIDTH - 1)) begin
                    cnt_d   = '0;
                    addr_d  = cmd_q ? addr_q + ADDR_WIDTH'(1) : addr_q;
                    ren_d   = cmd_q;
                    pend_d  = cmd_q;
                    wdata_d = cmd_q ? wdata_q : {rx_q[DATA_WIDTH-2:0], sdi_s};
                    wen_d   = ~cmd_q;
                    inc_d   = ~cmd_q;
                end
            end
            if (shift && state_q == DATA && cmd_q) begin
                if (cnt_q == '0 && pend_q && !read_valid_i) begin
                    urun_d = 1'b1;
                    pend_d = 1'b0;
                    tx_d   = '0;
                    sdo_d  = 1'b0;
                end else begin
                    sdo_d = tx_now[DATA_WIDTH-1];
                    tx_d  = {tx_now[DATA_WIDTH-2:0], 1'b0};
                end
            end
        end
    end
endmodule

// File: tb/tb_spi_slave_mem_bridge.sv
// tb_spi_slave_mem_bridge: drives SPI frames in all four modes against a memory model and checks bus and MISO traffic
module tb_spi_slave_mem_bridge;
    localparam int AW = 7;
    localparam int DW = 8;
    localparam int H  = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [3:0] sck_v = 4'b1100;
    logic [3:0] cs_v = 4'hf;
    logic [3:0] sdi_v = 4'h0;
    logic [3:0] sdo_v, oe_v, wen_v, ren_v, busy_v, ferr_v, urun_v;
    logic [AW-1:0] addr_v [4];
    logic [DW-1:0] wd_v [4];
    logic [DW-1:0] rdata = '0;
    logic rvalid = 1'b0;

    always #5 clk = ~clk;

    for (genvar m = 0; m < 4; m++) begin : g_dut
        spi_slave_mem_bridge #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SPI_MODE(m), .SYNC_STAGES(2)) u_dut (
            .clk_i(clk), .rst_ni(rst_n), .sck_i(sck_v[m]), .cs_ni(cs_v[m]), .sdi_i(sdi_v[m]),
            .sdo_o(sdo_v[m]), .sdo_oe_o(oe_v[m]), .addr_o(addr_v[m]), .write_data_o(wd_v[m]),
            .write_en_o(wen_v[m]), .read_en_o(ren_v[m]), .read_data_i(rdata), .read_valid_i(rvalid),
            .busy_o(busy_v[m]), .frame_err_o(ferr_v[m]), .rd_underrun_o(urun_v[m])
        );
    end

    logic [DW-1:0] mem [2**AW];
    logic [AW+DW-1:0] got_wr [$];
    logic [AW-1:0] got_rd [$];
    logic [DW-1:0] got_miso [$];
    logic [DW-1:0] dq [$];
    logic [AW-1:0] raddr = '0;
    int cur = 0, lat = 1, rcnt = 0;
    int n_ferr = 0, n_urun = 0, sdo_bad = 0, oe_bad = 0;
    int n_chk = 0, n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Bus monitor and memory responder for the DUT currently being exercised
    initial forever begin
        @(negedge clk);
        rvalid = 1'b0;
        if (rcnt > 0) begin
            rcnt--;
            if (rcnt == 0) begin
                rvalid = 1'b1;
                rdata  = mem[raddr];
            end
        end
        if (wen_v[cur]) got_wr.push_back({addr_v[cur], wd_v[cur]});
        if (ren_v[cur]) begin
            got_rd.push_back(addr_v[cur]);
            raddr = addr_v[cur];
            rcnt  = lat;
        end
        n_ferr += int'(ferr_v[cur]);
        n_urun += int'(urun_v[cur]);
        if (!oe_v[cur] && sdo_v[cur]) sdo_bad++;
    end

    task automatic frame(input int mode, input bit rd, input logic [AW-1:0] a, input int nw,
                         input int lt, input int stop_at, input bit by_rst);
        bit cpha;
        logic bq [$];
        int lim, nfull;
        logic [DW-1:0] miso;
        logic [AW-1:0] ea;
        cpha = mode[0];
        cur = mode;
        lat = lt;
        got_wr.delete();
        got_rd.delete();
        got_miso.delete();
        n_ferr = 0;
        n_urun = 0;
        sdo_bad = 0;
        oe_bad = 0;
        miso = '0;
        while (dq.size() < nw) dq.push_back(DW'($urandom));
        bq.push_back(rd);
        for (int i = AW - 1; i >= 0; i--) bq.push_back(a[i]);
        for (int k = 0; k < nw; k++)
            for (int i = DW - 1; i >= 0; i--) bq.push_back(dq[k][i]);
        lim = stop_at > 0 ? stop_at : bq.size();
        cs_v[mode] = 1'b0;
        repeat (H) @(negedge clk);
        for (int i = 0; i < lim; i++) begin
            if (cpha) sck_v[mode] = ~sck_v[mode];
            sdi_v[mode] = bq[i];
            repeat (H) @(negedge clk);
            if (i == 0) check("busy", 32'(busy_v[mode]), 1);
            if (oe_v[mode] !== (rd && i > AW)) oe_bad++;
            if (i > AW) begin
                miso = {miso[DW-2:0], sdo_v[mode]};
                if ((i - AW) % DW == 0) got_miso.push_back(miso);
            end
            sck_v[mode] = ~sck_v[mode];
            repeat (H) @(negedge clk);
            if (!cpha) sck_v[mode] = ~sck_v[mode];
        end
        if (by_rst) begin
            rst_n = 1'b0;
            repeat (2) @(negedge clk);
            cs_v[mode] = 1'b1;
            repeat (4) @(negedge clk);
            rst_n = 1'b1;
        end else begin
            repeat (H) @(negedge clk);
            cs_v[mode] = 1'b1;
        end
        repeat (30) @(negedge clk);
        check("busy_end", 32'(busy_v[mode]), 0);
        nfull = lim > AW + 1 ? (lim - AW - 1) / DW : 0;
        if (!rd) begin
            check("wr_cnt", got_wr.size(), nfull);
            for (int k = 0; k < nfull && k < got_wr.size(); k++) begin
                ea = a + AW'(k);
                check("wr", 32'(got_wr[k]), 32'({ea, dq[k]}));
                mem[ea] = dq[k];
            end
        end else begin
            check("rd_cnt", got_rd.size(), nw + 1);
            for (int k = 0; k <= nw && k < got_rd.size(); k++) begin
                ea = a + AW'(k);
                check("rd_addr", 32'(got_rd[k]), 32'(ea));
            end
            check("miso_cnt", got_miso.size(), nw);
            for (int k = 0; k < nw && k < got_miso.size(); k++) begin
                ea = a + AW'(k);
                check("miso", 32'(got_miso[k]), lt > 10 ? 0 : 32'(mem[ea]));
            end
        end
        check("urun", n_urun, (rd && lt > 10) ? nw + (cpha ? 0 : 1) : 0);
        check("ferr", n_ferr, (!by_rst && (lim < AW + 1 || (lim - AW - 1) % DW != 0)) ? 1 : 0);
        check("oe", oe_bad, 0);
        check("sdo_gate", sdo_bad, 0);
        dq.delete();
    endtask

    initial begin
        int l;
        for (int i = 0; i < 2**AW; i++) mem[i] = DW'($urandom);
        repeat (3) @(negedge clk);
        for (int m = 0; m < 4; m++)
            check("rst", 32'({addr_v[m], wd_v[m], sdo_v[m], oe_v[m], wen_v[m], ren_v[m],
                              busy_v[m], ferr_v[m], urun_v[m]}), 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        dq = '{8'hA5};
        frame(0, 1'b0, 7'h12, 1, 1, 0, 1'b0);
        dq = '{8'h11, 8'h22, 8'h33};
        frame(3, 1'b0, 7'h7F, 3, 1, 0, 1'b0);
        mem[5] = 8'h3C;
        frame(1, 1'b1, 7'h05, 1, 2, 0, 1'b0);
        frame(2, 1'b1, 7'h40, 2, 3, 0, 1'b0);
        frame(1, 1'b1, 7'h21, 1, 20, 0, 1'b0);
        dq = '{8'hC3};
        frame(0, 1'b0, 7'h30, 1, 1, 12, 1'b0);
        dq = '{8'h5A};
        frame(0, 1'b0, 7'h01, 1, 1, 0, 1'b0);
        frame(0, 1'b0, 7'h44, 1, 1, 5, 1'b1);
        for (int t = 0; t < 20; t++) begin
            l = ($urandom_range(0, 4) == 4) ? 20 : int'($urandom_range(1, 4));
            frame(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), AW'($urandom),
                  int'($urandom_range(1, 3)), l, 0, 1'b0);
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
